// File: rtl/ss_map_pkg.sv
// Shared types and address helper for the sidescroller map probe.
package ss_map_pkg;

    localparam int COLS_LOG2_DEF = 7;
    localparam int ROWS_LOG2_DEF = 7;
    localparam int ADDR_W        = 14;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        SOLID  = 2'd1,
        HAZARD = 2'd2,
        GOAL   = 2'd3
    } tile_t;

    typedef enum logic [1:0] {
        HERE  = 2'd0,
        BELOW = 2'd1,
        AHEAD = 2'd2,
        ABOVE = 2'd3
    } probe_idx_t;

    typedef struct packed {
        logic       vld;
        probe_idx_t idx;
        logic       oob;
    } tag_t;

    typedef struct packed {
        tile_t here;
        tile_t below;
        tile_t ahead;
        tile_t above;
        logic  grounded;
        logic  blocked;
        logic  hazard;
        logic  goal;
    } res_t;

    // Map layout is row-major: {row, col}.
    function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] row,
                                                   input logic [ADDR_W-1:0] col,
                                                   input int cols_log2);
        return (row << cols_log2) | col;
    endfunction

endpackage

// File: rtl/ss_map_probe.sv
// Reads the four tiles around the player from the map muxer port and
// publishes them with derived collision flags in one registered update.
module ss_map_probe
    import ss_map_pkg::*;
#(
    parameter int RD_LAT    = 1,
    parameter int COLS_LOG2 = COLS_LOG2_DEF,
    parameter int ROWS_LOG2 = ROWS_LOG2_DEF
) (
    input  logic                 clk_75,
    input  logic                 reset,
    input  logic                 probe_req,
    input  logic [COLS_LOG2-1:0] probe_col,
    input  logic [ROWS_LOG2-1:0] probe_row,
    input  logic                 probe_dir,
    output logic [ADDR_W-1:0]    worldmap_addr,
    input  logic [1:0]           worldmap_data,
    output logic                 probe_busy,
    output logic                 probe_done,
    output logic [1:0]           tile_here,
    output logic [1:0]           tile_below,
    output logic [1:0]           tile_ahead,
    output logic [1:0]           tile_above,
    output logic                 grounded,
    output logic                 blocked,
    output logic                 hazard,
    output logic                 goal
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    // Neighbour coordinates carry one extra bit so under/overflow shows up as the MSB.
    function automatic logic [ROWS_LOG2:0] nb_row(input probe_idx_t k, input logic [ROWS_LOG2-1:0] row);
        logic [ROWS_LOG2:0] r;
        r = {1'b0, row};
        case (k)
            BELOW:   r = r + (ROWS_LOG2+1)'(1);
            ABOVE:   r = r - (ROWS_LOG2+1)'(1);
            default: r = {1'b0, row};
        endcase
        return r;
    endfunction

    function automatic logic [COLS_LOG2:0] nb_col(input probe_idx_t k, input logic [COLS_LOG2-1:0] col,
                                                  input logic dir);
        logic [COLS_LOG2:0] c;
        c = {1'b0, col};
        if (k == AHEAD)
            c = dir ? c + (COLS_LOG2+1)'(1) : c - (COLS_LOG2+1)'(1);
        return c;
    endfunction

    function automatic logic slot_oob(input probe_idx_t k, input logic [ROWS_LOG2-1:0] row,
                                      input logic [COLS_LOG2-1:0] col, input logic dir);
        logic [ROWS_LOG2:0] r;
        logic [COLS_LOG2:0] c;
        r = nb_row(k, row);
        c = nb_col(k, col, dir);
        return r[ROWS_LOG2] | c[COLS_LOG2];
    endfunction

    function automatic logic [ADDR_W-1:0] slot_addr(input probe_idx_t k, input logic [ROWS_LOG2-1:0] row,
                                                    input logic [COLS_LOG2-1:0] col, input logic dir);
        logic [ROWS_LOG2:0] r;
        logic [COLS_LOG2:0] c;
        r = nb_row(k, row);
        c = nb_col(k, col, dir);
        if (slot_oob(k, row, col, dir))
            return map_addr(ADDR_W'(row), ADDR_W'(col), COLS_LOG2);
        return map_addr(ADDR_W'(r), ADDR_W'(c), COLS_LOG2);
    endfunction

    state_t               state_q, state_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [ROWS_LOG2-1:0] row_q, row_d;
    logic [COLS_LOG2-1:0] col_q, col_d;
    logic                 dir_q, dir_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    tile_t [3:0]          stage_q, stage_d;
    tag_t                 tag_q [RD_LAT];
    tag_t                 tag_d [RD_LAT];
    res_t                 res_q, res_d;
    logic                 done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        dir_d   = dir_q;
        addr_d  = addr_q;
        stage_d = stage_q;
        res_d   = res_q;
        done_d  = 1'b0;

        tag_d[0] = '0;
        for (int i = 1; i < RD_LAT; i++)
            tag_d[i] = tag_q[i-1];

        // Tag leaving the pipe lines up with the data for that slot.
        if (tag_q[RD_LAT-1].vld)
            stage_d[tag_q[RD_LAT-1].idx] = tag_q[RD_LAT-1].oob ? SOLID : tile_t'(worldmap_data);

        case (state_q)
            S_IDLE: begin
                if (probe_req) begin
                    state_d = S_ISSUE;
                    cnt_d   = '0;
                    row_d   = probe_row;
                    col_d   = probe_col;
                    dir_d   = probe_dir;
                    addr_d  = map_addr(ADDR_W'(probe_row), ADDR_W'(probe_col), COLS_LOG2);
                end
            end
            S_ISSUE: begin
                tag_d[0] = '{vld: 1'b1, idx: probe_idx_t'(cnt_q),
                             oob: slot_oob(probe_idx_t'(cnt_q), row_q, col_q, dir_q)};
                if (cnt_q == 2'd3) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d  = cnt_q + 2'd1;
                    addr_d = slot_addr(probe_idx_t'(cnt_q + 2'd1), row_q, col_q, dir_q);
                end
            end
            S_DRAIN: begin
                if (cnt_q == 2'(RD_LAT-1)) begin
                    state_d        = S_IDLE;
                    done_d         = 1'b1;
                    res_d.here     = stage_d[HERE];
                    res_d.below    = stage_d[BELOW];
                    res_d.ahead    = stage_d[AHEAD];
                    res_d.above    = stage_d[ABOVE];
                    res_d.grounded = (stage_d[BELOW] == SOLID);
                    res_d.blocked  = (stage_d[AHEAD] == SOLID);
                    res_d.hazard   = (stage_d[HERE] == HAZARD) || (stage_d[BELOW] == HAZARD) ||
                                     (stage_d[AHEAD] == HAZARD) || (stage_d[ABOVE] == HAZARD);
                    res_d.goal     = (stage_d[HERE] == GOAL);
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_75) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            dir_q   <= 1'b0;
            addr_q  <= '0;
            stage_q <= {4{EMPTY}};
            tag_q   <= '{default: '0};
            res_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            dir_q   <= dir_d;
            addr_q  <= addr_d;
            stage_q <= stage_d;
            tag_q   <= tag_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    assign worldmap_addr = addr_q;
    assign probe_busy    = (state_q != S_IDLE);
    assign probe_done    = done_q;
    assign tile_here     = res_q.here;
    assign tile_below    = res_q.below;
    assign tile_ahead    = res_q.ahead;
    assign tile_above    = res_q.above;
    assign grounded      = res_q.grounded;
    assign blocked       = res_q.blocked;
    assign hazard        = res_q.hazard;
    assign goal          = res_q.goal;

endmodule

// File: tb/tb_ss_map_probe.sv
// Scoreboard bench: two builds (read latency 1 and 3) share one stimulus stream
// and one array-backed map; expectations come from a coordinate-level model.
module tb_ss_map_probe;

    localparam int NI = 2;

    logic       clk_75 = 1'b0;
    logic       reset;
    logic       probe_req;
    logic [6:0] probe_col;
    logic [6:0] probe_row;
    logic       probe_dir;

    logic [13:0] w_addr [NI];
    logic [1:0]  w_data [NI];
    logic        busy [NI];
    logic        done [NI];
    logic [1:0]  t_here [NI];
    logic [1:0]  t_below [NI];
    logic [1:0]  t_ahead [NI];
    logic [1:0]  t_above [NI];
    logic        o_gr [NI];
    logic        o_bl [NI];
    logic        o_hz [NI];
    logic        o_gl [NI];

    logic [1:0] map_mem [16384];

    int edge_n    = 0;
    int checks    = 0;
    int failures  = 0;
    int rst_chk_e = -1;
    int free_e [NI];
    bit fin       = 1'b0;
    bit fin_done  = 1'b0;

    typedef struct { int e; logic [13:0] a; } aexp_t;
    typedef struct { int e; logic [7:0] t; logic [3:0] f; } dexp_t;

    aexp_t aq [NI][$];
    dexp_t dq [NI][$];

    always #5 clk_75 = ~clk_75;

    always @(posedge clk_75) edge_n <= edge_n + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : 3;
        logic [1:0] rd_pipe [L];

        always @(posedge clk_75) begin
            rd_pipe[0] <= map_mem[w_addr[g]];
            for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
        assign w_data[g] = rd_pipe[L-1];

        ss_map_probe #(.RD_LAT(L)) dut (
            .clk_75       (clk_75),
            .reset        (reset),
            .probe_req    (probe_req),
            .probe_col    (probe_col),
            .probe_row    (probe_row),
            .probe_dir    (probe_dir),
            .worldmap_addr(w_addr[g]),
            .worldmap_data(w_data[g]),
            .probe_busy   (busy[g]),
            .probe_done   (done[g]),
            .tile_here    (t_here[g]),
            .tile_below   (t_below[g]),
            .tile_ahead   (t_ahead[g]),
            .tile_above   (t_above[g]),
            .grounded     (o_gr[g]),
            .blocked      (o_bl[g]),
            .hazard       (o_hz[g]),
            .goal         (o_gl[g])
        );
    end

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Neighbour k of (r,c): out-of-range coordinates read the player tile but yield SOLID.
    function automatic void nb(input int k, input int r, input int c, input bit d,
                               output int a, output logic [1:0] t);
        int nr = r;
        int nc = c;
        if (k == 1) nr = r + 1;
        if (k == 2) nc = d ? c + 1 : c - 1;
        if (k == 3) nr = r - 1;
        if (nr < 0 || nr > 127 || nc < 0 || nc > 127) begin
            a = r * 128 + c;
            t = 2'd1;
        end else begin
            a = nr * 128 + nc;
            t = map_mem[a];
        end
    endfunction

    // Reference: decide acceptance and enqueue expected addresses and results.
    always @(posedge clk_75) begin
        if (reset) begin
            for (int i = 0; i < NI; i++) begin
                aq[i].delete();
                dq[i].delete();
                free_e[i] = 0;
            end
            rst_chk_e = edge_n + 1;
        end else if (probe_req) begin
            for (int i = 0; i < NI; i++) begin
                if (edge_n >= free_e[i]) begin
                    dexp_t x;
                    logic [1:0] tk [4];
                    int a;
                    for (int k = 0; k < 4; k++) begin
                        nb(k, int'(probe_row), int'(probe_col), probe_dir, a, tk[k]);
                        aq[i].push_back('{edge_n + 1 + k, 14'(a)});
                    end
                    x.e = edge_n + 5 + lat(i);
                    x.t = {tk[0], tk[1], tk[2], tk[3]};
                    x.f = {tk[1] == 2'd1, tk[2] == 2'd1,
                           (tk[0] == 2'd2 || tk[1] == 2'd2 || tk[2] == 2'd2 || tk[3] == 2'd2),
                           tk[0] == 2'd3};
                    dq[i].push_back(x);
                    free_e[i] = x.e;
                end
            end
        end
    end

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d edge=%0d got=%0h want=%0h", nm, i, edge_n, act, exp);
        end
    endtask

    always @(negedge clk_75) begin
        for (int i = 0; i < NI; i++) begin
            logic [11:0] outs;
            logic        exp_busy;
            outs = {t_here[i], t_below[i], t_ahead[i], t_above[i], o_gr[i], o_bl[i], o_hz[i], o_gl[i]};
            exp_busy = (dq[i].size() > 0) && (edge_n < dq[i][0].e);
            chk("busy", i, 32'(busy[i]), 32'(exp_busy));

            if (edge_n == rst_chk_e) begin
                chk("reset_outs", i, 32'(outs), 32'd0);
                chk("reset_addr", i, 32'(w_addr[i]), 32'd0);
                chk("reset_done", i, 32'(done[i]), 32'd0);
            end

            if (aq[i].size() > 0 && aq[i][0].e == edge_n) begin
                aexp_t ax;
                ax = aq[i].pop_front();
                chk("addr", i, 32'(w_addr[i]), 32'(ax.a));
            end

            if (dq[i].size() > 0 && dq[i][0].e == edge_n) begin
                dexp_t x;
                x = dq[i].pop_front();
                chk("done", i, 32'(done[i]), 32'd1);
                chk("results", i, 32'(outs), 32'({x.t, x.f}));
            end else if (done[i]) begin
                chk("spurious_done", i, 32'(done[i]), 32'd0);
            end

            if (fin && !fin_done) begin
                chk("leftover_addr", i, 32'(aq[i].size()), 32'd0);
                chk("leftover_done", i, 32'(dq[i].size()), 32'd0);
            end
        end
        if (fin) fin_done = 1'b1;
    end

    task automatic probe(input int r, input int c, input bit d);
        @(negedge clk_75);
        probe_req = 1'b1;
        probe_row = 7'(r);
        probe_col = 7'(c);
        probe_dir = d;
        @(negedge clk_75);
        probe_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_75);
    endtask

    initial begin
        reset     = 1'b1;
        probe_req = 1'b0;
        probe_row = '0;
        probe_col = '0;
        probe_dir = 1'b0;
        for (int a = 0; a < 16384; a++) map_mem[a] = 2'($urandom_range(0, 3));
        map_mem[10*128+20] = 2'd0;
        map_mem[11*128+20] = 2'd1;
        map_mem[10*128+21] = 2'd2;
        map_mem[9*128+20]  = 2'd0;
        map_mem[10*128+19] = 2'd1;
        idle(3);
        reset = 1'b0;

        probe(10, 20, 1'b1); idle(10);
        probe(10, 20, 1'b0); idle(10);
        probe(127, 0, 1'b0); idle(10);
        probe(0, 127, 1'b1); idle(10);

        // Request held high: one accept per completed probe.
        @(negedge clk_75);
        probe_req = 1'b1;
        for (int n = 0; n < 25; n++) begin
            probe_row = 7'($urandom);
            probe_col = 7'($urandom);
            probe_dir = 1'($urandom);
            @(negedge clk_75);
        end
        probe_req = 1'b0;
        idle(10);

        // Short pulses, many landing while busy.
        for (int n = 0; n < 30; n++) begin
            probe_req = (n % 3 == 0);
            probe_row = 7'($urandom);
            probe_col = 7'($urandom);
            probe_dir = 1'($urandom);
            @(negedge clk_75);
        end
        probe_req = 1'b0;
        idle(10);

        // Reset in the middle of a probe, then restart.
        @(negedge clk_75);
        probe_req = 1'b1; probe_row = 7'd10; probe_col = 7'd20; probe_dir = 1'b1;
        @(negedge clk_75);
        probe_req = 1'b0;
        @(negedge clk_75);
        @(negedge clk_75);
        reset = 1'b1;
        @(negedge clk_75);
        reset = 1'b0;
        @(negedge clk_75);
        probe_req = 1'b1;
        @(negedge clk_75);
        probe_req = 1'b0;
        idle(12);

        // Random probes, edges of the map favoured.
        for (int n = 0; n < 40; n++) begin
            int r;
            int c;
            r = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 127 : 0) : int'($urandom_range(0, 127));
            c = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 127 : 0) : int'($urandom_range(0, 127));
            probe(r, c, 1'($urandom));
            idle(int'($urandom_range(0, 8)));
        end
        idle(15);

        fin = 1'b1;
        idle(3);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ss_map_probe.md
# ss_map_probe

Tile-neighbourhood reader for the sidescroller world map. On request it issues four sequential reads on the game-logic port of the map muxer (`worldmap_addr` / `worldmap_data`). The four reads cover the player's tile, the tile below, the tile ahead and the tile above. It then reports the four tile codes plus derived collision flags to the player-physics logic in one registered update. It is the initiator side of the map muxer's port A, and the muxer's map selection is transparent to it.

## Interface
Parameters:
- `RD_LAT`, default 1: cycles from `worldmap_addr` presented to `worldmap_data` valid. Legal values are 1–3.
- `COLS_LOG2`, default 7: log2 of the map width in tiles.
- `ROWS_LOG2`, default 7: log2 of the map height in tiles. `COLS_LOG2 + ROWS_LOG2` must equal 14.

Ports:
- `clk_75` in 1: system clock. It is the only clock in the block.
- `reset` in 1: reset, synchronous, active-high.
- `probe_req` in 1: start a probe. Sampled only when idle.
- `probe_col` in 7: player tile column.
- `probe_row` in 7: player tile row.
- `probe_dir` in 1: facing direction. 1 = right, 0 = left.
- `worldmap_addr` out 14: map read address, `{row, col}`.
- `worldmap_data` in 2: tile code returned by the map.
- `probe_busy` out 1: a probe is in flight.
- `probe_done` out 1: one-cycle pulse. All results are valid from this cycle on.
- `tile_here`, `tile_below`, `tile_ahead`, `tile_above` out 2 each: tile codes.
- `grounded` out 1: `tile_below` == SOLID.
- `blocked` out 1: `tile_ahead` == SOLID.
- `hazard` out 1: any of the four tiles == HAZARD.
- `goal` out 1: `tile_here` == GOAL.

## Operation
- Tile codes:
  - 0 EMPTY
  - 1 SOLID
  - 2 HAZARD
  - 3 GOAL
- FSM states:
  - IDLE → ISSUE when `probe_req` is high. `probe_col`, `probe_row` and `probe_dir` are latched on that edge.
  - ISSUE lasts 4 cycles, with index k = 0..3.
  - ISSUE → DRAIN.
  - DRAIN lasts RD_LAT cycles.
  - DRAIN → IDLE. `probe_done` pulses in the first IDLE cycle.
- Probe order and addresses:
  - k=0: here, `(row, col)`.
  - k=1: below, `(row+1, col)`.
  - k=2: ahead, `(row, col+1)` if `dir`, else `(row, col-1)`.
  - k=3: above, `(row-1, col)`.
- Boundary cases:
  - Out of bounds means row+1 > max row, row−1 < 0, col+1 > max col, or col−1 < 0. Neighbour arithmetic is done one bit wider, so there is no wrap.
  - For an out-of-bounds probe, the slot still issues and drives the "here" address. The captured result is forced to SOLID.
- Capture:
  - A shift register of depth RD_LAT tags each issued slot with its index and its OOB bit.
  - Data is written into a staging register when the tag emerges.
  - Results and flags copy from staging to the outputs together, in the `probe_done` cycle only. Outputs never show a partial update.
- `probe_req` while busy is ignored, not queued.
- `probe_req` high in the `probe_done` cycle is accepted, so back-to-back probes work.
- `worldmap_addr` holds its last value while idle.

## Timing
- `probe_req` is sampled high at edge T.
  - Addresses are valid in cycles T+1 .. T+4.
  - Data is valid in cycles T+1+RD_LAT .. T+4+RD_LAT.
  - `probe_done` and the new results appear in cycle T+5+RD_LAT, i.e. T+6 for RD_LAT=1.
- `probe_busy` is high in cycles T+1 .. T+4+RD_LAT and low in the done cycle.
- Reset values: all outputs are 0, `worldmap_addr` is 0, tiles are EMPTY, the FSM is IDLE.
- Reset mid-probe:
  - The FSM returns to IDLE and staging and tags are cleared.
  - No `probe_done` is generated.
  - Outputs take their reset values on the next edge.

## Structure
- Package `ss_map_pkg` holds:
  - the `tile_t` enum (EMPTY/SOLID/HAZARD/GOAL);
  - the `COLS_LOG2` and `ROWS_LOG2` defaults;
  - the probe index enum (HERE/BELOW/AHEAD/ABOVE);
  - the function `map_addr(row, col)`.
- There is no sub-module. The FSM, the address generator and the tag pipeline sit in one module.

## Test plan
- Bench model: an array-backed map with RD_LAT=1. Tile (10,20) is EMPTY, (11,20) SOLID, (10,21) HAZARD, (9,20) EMPTY.
  - Stimulus: req with row=10, col=20, dir=1 at T.
  - Required: addresses 0x0514, 0x0594, 0x0515, 0x0494 in T+1..T+4.
  - Required at T+6: done=1, grounded=1, blocked=0, hazard=1, goal=0.
- Same map, dir=0, (10,19)=SOLID → ahead address 0x0513, blocked=1.
- row=127, col=0, dir=0 → below and ahead both forced to SOLID; grounded=1, blocked=1. Slots 1 and 2 drive address 0x3F80.
- Req held high continuously → done every 6 cycles. Reqs pulsed during busy produce no extra done.
- Reset asserted at T+3 → no done; all outputs 0 at T+4. A new req at T+5 completes at T+11.
- RD_LAT=3 build → addresses T+1..T+4, done at T+8, same results as the first scenario.
